// File: rtl/seq_alu_pkg.sv
// Shared op codes and controller states for the sequential ALU.
package seq_alu_pkg;

  typedef enum logic [2:0] {
    PASS_A = 3'd0,
    PASS_B = 3'd1,
    ADD    = 3'd2,
    SUB    = 3'd3,
    NOR    = 3'd4,
    MUL    = 3'd5
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle.
module seq_alu_mul #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic              busy;
  logic [CW-1:0]     count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc_next;

  // Next accumulator value; on the final step this is the finished product,
  // exposed combinationally so the controller registers it on that same edge.
  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
  end

  assign product = acc_next;
  assign done    = busy && (count == LAST);

  // Operand latch on start, then one shift-add step per cycle for WIDTH cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      count  <= '0;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (count == LAST) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops plus iterative multiply, valid/ready on both sides.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             not_carry_in,
  input  logic [WIDTH-1:0] a_port,
  input  logic [WIDTH-1:0] b_port,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out,
  output logic             zero_out
);

  state_t             state;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic [WIDTH-1:0]   alu_data;
  logic               alu_carry;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign in_ready  = (state == ST_IDLE) && !reset;
  assign mul_start = in_valid && in_ready && (op == MUL);
  assign zero_out  = out_valid && (data_out == '0);

  // Single-cycle result path; the SUB borrow bit is exactly the A < B flag.
  always_comb begin
    add_sum   = {1'b0, a_port} + {1'b0, b_port} + {{WIDTH{1'b0}}, ~not_carry_in};
    sub_diff  = {1'b0, a_port} - {1'b0, b_port};
    alu_data  = '0;
    alu_carry = 1'b0;
    case (op)
      PASS_A: alu_data = a_port;
      PASS_B: alu_data = b_port;
      ADD: begin
        alu_data  = add_sum[WIDTH-1:0];
        alu_carry = add_sum[WIDTH];
      end
      SUB: begin
        alu_data  = sub_diff[WIDTH-1:0];
        alu_carry = sub_diff[WIDTH];
      end
      NOR:     alu_data = ~(a_port | b_port);
      default: begin
        alu_data  = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (a_port),
    .b       (b_port),
    .done    (mul_done),
    .product (mul_product)
  );

  // Controller state and registered result/flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      data_out  <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (op == MUL) begin
              state <= ST_MUL;
            end else begin
              data_out  <= alu_data;
              carry_out <= alu_carry;
              out_valid <= 1'b1;
              state     <= ST_HOLD;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            data_out  <= mul_product[WIDTH-1:0];
            carry_out <= |mul_product[2*WIDTH-1:WIDTH];
            out_valid <= 1'b1;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at WIDTH=4.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic         not_carry_in;
  logic [W-1:0] a_port;
  logic [W-1:0] b_port;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] data_out;
  logic         carry_out;
  logic         zero_out;

  typedef struct {
    int data;
    int carry;
    int zero;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op           (op),
    .not_carry_in (not_carry_in),
    .a_port       (a_port),
    .b_port       (b_port),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .data_out     (data_out),
    .carry_out    (carry_out),
    .zero_out     (zero_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input int a, input int b, input logic nci);
    exp_t e;
    int   s;
    e.data  = 0;
    e.carry = 0;
    case (o)
      3'd0: e.data = a;
      3'd1: e.data = b;
      3'd2: begin
        s = a + b + (nci ? 0 : 1);
        e.data  = s % 16;
        e.carry = (s >= 16) ? 1 : 0;
      end
      3'd3: begin
        e.data  = (a - b + 16) % 16;
        e.carry = (a < b) ? 1 : 0;
      end
      3'd4: e.data = 15 - (a | b);
      3'd5: begin
        s = a * b;
        e.data  = s % 16;
        e.carry = (s >= 16) ? 1 : 0;
      end
      default: ;
    endcase
    e.zero = (e.data == 0) ? 1 : 0;
    return e;
  endfunction

  // Issue one request, wait for its result, optionally stall the consumer.
  task automatic run_op(input logic [2:0] o, input int a, input int b, input logic nci,
                        input int hold);
    exp_t e;
    int   lat;
    int   waits;
    int   want_lat;
    want_lat = (o == 3'd5) ? W + 1 : 1;
    @(negedge clk);
    waits = 0;
    while (!in_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    check("in_ready_before_accept", int'(in_ready), 1);
    in_valid     = 1'b1;
    op           = o;
    a_port       = W'(a);
    b_port       = W'(b);
    not_carry_in = nci;
    exp_q.push_back(model(o, a, b, nci));
    @(negedge clk);
    lat = 1;
    // Keep presenting junk requests; they must be ignored while busy.
    in_valid = 1'b1;
    op       = 3'($urandom_range(0, 7));
    a_port   = W'($urandom);
    b_port   = W'($urandom);
    while (!out_valid && lat < 40) begin
      check("in_ready_low_busy", int'(in_ready), 0);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, want_lat);
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      for (int h = 0; h < hold; h++) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_data", int'(data_out), e.data);
        check("hold_ready_low", int'(in_ready), 0);
        a_port = W'($urandom);
        @(negedge clk);
      end
      check("data", int'(data_out), e.data);
      check("carry", int'(carry_out), e.carry);
      check("zero", int'(zero_out), e.zero);
      check("valid", int'(out_valid), 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_dropped", int'(out_valid), 0);
    check("ready_after_consume", int'(in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises;
    reset        = 1'b1;
    in_valid     = 1'b0;
    op           = 3'd0;
    not_carry_in = 1'b1;
    a_port       = '0;
    b_port       = '0;
    out_ready    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_data", int'(data_out), 0);
    check("rst_carry", int'(carry_out), 0);
    check("rst_zero", int'(zero_out), 0);
    reset = 1'b0;
    #1;
    check("in_ready_after_rst", int'(in_ready), 1);

    // out_ready with nothing held must do nothing.
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("spurious_out_ready", int'(out_valid), 0);
    out_ready = 1'b0;

    run_op(ADD,    9, 8, 1'b1, 0);
    run_op(ADD,    7, 8, 1'b0, 0);
    run_op(SUB,    3, 5, 1'b1, 0);
    run_op(SUB,    5, 3, 1'b1, 0);
    run_op(NOR,    5, 10, 1'b1, 0);
    run_op(PASS_B, 9, 6, 1'b1, 0);
    run_op(PASS_A, 12, 6, 1'b0, 0);
    run_op(MUL,    7, 5, 1'b1, 0);
    run_op(MUL,    3, 5, 1'b1, 0);
    run_op(MUL,   15, 15, 1'b1, 0);
    run_op(3'd6,   9, 9, 1'b0, 0);
    run_op(3'd7,   1, 2, 1'b1, 0);
    run_op(ADD,   15, 0, 1'b0, 3);
    run_op(MUL,    6, 7, 1'b1, 3);

    for (int i = 0; i < 12; i++) begin
      run_op(3'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 2)));
    end

    // Reset two cycles into a multiply: the operation must vanish.
    @(negedge clk);
    in_valid = 1'b1;
    op       = MUL;
    a_port   = 4'd7;
    b_port   = 4'd5;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_valid", int'(out_valid), 0);
    check("abort_data", int'(data_out), 0);
    check("abort_carry", int'(carry_out), 0);
    check("abort_zero", int'(zero_out), 0);
    check("abort_in_ready", int'(in_ready), 1);
    rises = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) rises++;
    end
    check("abort_no_result", rises, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
